// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result interface of the sequential divider
interface seq_divider_if #(
   parameter int WIDTH = 16
);
   logic             valid_in;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             valid_out;

   modport master (
      output valid_in, dividend, divisor,
      input  busy, quotient, remainder, div_by_zero, valid_out
   );

   modport slave (
      input  valid_in, dividend, divisor,
      output busy, quotient, remainder, div_by_zero, valid_out
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock; DIVIDER_SIGNED_EN selects two's complement operands
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH:0]   rem_acc;
   logic [WIDTH-1:0] q_acc;
   logic [WIDTH-1:0] dvs_mag_r;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quotient_r, remainder_r;
   logic             dz_r;
   logic             busy_c, valid_c;

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   trial, rem_nxt;
   logic             ge;
   logic [WIDTH-1:0] q_nxt;
   logic             last;
   logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fix, r_fix;

   // Magnitudes at accept and sign fix-up folded into the final result write
`ifdef DIVIDER_SIGNED_EN
   logic q_neg, r_neg;
   assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
   assign q_fix   = q_neg ? -q_nxt : q_nxt;
   assign r_fix   = r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
`else
   assign dvd_mag = bus.dividend;
   assign dvs_mag = bus.divisor;
   assign q_fix   = q_nxt;
   assign r_fix   = rem_nxt[WIDTH-1:0];
`endif

   // One restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      shifted = {rem_acc, q_acc[WIDTH-1]};
      ge      = (shifted >= {2'b00, dvs_mag_r});
      trial   = shifted[WIDTH:0] - {1'b0, dvs_mag_r};
      rem_nxt = ge ? trial : shifted[WIDTH:0];
      q_nxt   = {q_acc[WIDTH-2:0], ge};
      last    = (count == CW'(WIDTH - 1));
   end

   // Controller state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      valid_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.valid_in) begin
               state_nxt = (bus.divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            busy_c = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_c    = 1'b1;
            valid_c   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_acc     <= '0;
         q_acc       <= '0;
         dvs_mag_r   <= '0;
         count       <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dz_r        <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.valid_in) begin
                  if (bus.divisor == '0) begin
                     quotient_r  <= '1;
                     remainder_r <= bus.dividend;
                     dz_r        <= 1'b1;
                  end else begin
                     rem_acc   <= '0;
                     q_acc     <= dvd_mag;
                     dvs_mag_r <= dvs_mag;
                     count     <= '0;
`ifdef DIVIDER_SIGNED_EN
                     q_neg     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                     r_neg     <= bus.dividend[WIDTH-1];
`endif
                  end
               end
            end
            CALC: begin
               rem_acc <= rem_nxt;
               q_acc   <= q_nxt;
               count   <= count + 1'b1;
               if (last) begin
                  quotient_r  <= q_fix;
                  remainder_r <= r_fix;
                  dz_r        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_c;
   assign bus.valid_out   = valid_c;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;
   localparam int W = 16;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz);
      longint sa, sb;
      sa = longint'(a);
      sb = longint'(b);
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
`ifdef DIVIDER_SIGNED_EN
         sa = longint'($signed(a));
         sb = longint'($signed(b));
`endif
         q  = W'(sa / sb);
         r  = W'(sa % sb);
         dz = 1'b0;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int inject_at, input string tag);
      int n;
      logic busy_ok;
      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.valid_in = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      n       = 1;
      busy_ok = 1'b1;
      while (n <= 40) begin
         if (n == inject_at) begin
            bus.valid_in = 1'b1;
            bus.dividend = W'($urandom);
            bus.divisor  = W'($urandom);
         end
         busy_ok = busy_ok & bus.busy;
         if (bus.valid_out) break;
         @(posedge clk);
         #1;
         bus.valid_in = 1'b0;
         n++;
      end
      bus.valid_in = 1'b0;
      chk({tag, " latency"}, 64'(n), edz ? 64'd1 : 64'(W + 1));
      chk({tag, " busy"}, 64'(busy_ok), 64'd1);
      chk({tag, " quotient"}, 64'(bus.quotient), 64'(eq));
      chk({tag, " remainder"}, 64'(bus.remainder), 64'(er));
      chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edz));
   endtask

   task automatic run_model(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      logic [W-1:0] q, r;
      logic dz;
      model(a, b, q, r, dz);
      run_op(a, b, q, r, dz, 0, tag);
   endtask

   initial begin
      logic [W-1:0] ra, rb;

      reset        = 1'b0;
      bus.valid_in = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst quotient", 64'(bus.quotient), 64'd0);
      chk("rst remainder", 64'(bus.remainder), 64'd0);
      chk("rst div_by_zero", 64'(bus.div_by_zero), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 0, "100/7");
      run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0, "FFFF/1");
      run_op(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 0, "5/9");
      run_op(16'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1'b1, 0, "1234/0");
      run_op(16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 0, "10/3");
      run_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 5, "inject 1000/33");
      run_op(16'd77, 16'd0, 16'hFFFF, 16'd77, 1'b1, 0, "77/0");
      run_op(16'd77, 16'd0, 16'hFFFF, 16'd77, 1'b1, 0, "77/0 again");
      run_op(16'd200, 16'd20, 16'd10, 16'd0, 1'b0, 0, "200/20");

      @(negedge clk);
      while (bus.busy) @(negedge clk);
      bus.valid_in = 1'b1;
      bus.dividend = 16'd500;
      bus.divisor  = 16'd3;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort quotient", 64'(bus.quotient), 64'd0);
      chk("abort remainder", 64'(bus.remainder), 64'd0);
      chk("abort busy", 64'(bus.busy), 64'd0);
      chk("abort valid_out", 64'(bus.valid_out), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("abort no valid_out", 64'(bus.valid_out), 64'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("post-abort idle valid_out", 64'(bus.valid_out), 64'd0);
      end
      run_op(16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 0, "9/2");

`ifdef DIVIDER_SIGNED_EN
      run_op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 0, "-7/2");
      run_op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 0, "7/-2");
      run_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 0, "8000/FFFF");
`endif

      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         if (i % 6 == 0) begin
            rb = '0;
         end else if (i % 3 == 0) begin
            rb = W'($urandom_range(1, 15));
         end else begin
            rb = W'($urandom);
         end
         run_model(ra, rb, $sformatf("rand%0d", i));
      end

      @(posedge clk);
      #1;
      chk("pulse ends", 64'(bus.valid_out), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
